morph_filter_stream: RTL and testbench
======================================

// Module: morph_filter_stream
// PURPOSE
//  Streaming 3x3 binary morphology on 1-bit raster-scan frames, IMG_W x IMG_H pixels.
//  Per-frame selectable erosion / dilation / morphological edge / bypass; border-aware (out-of-frame taps ignored).
//  Valid/ready input, frame markers in and out, self-flushing at end of frame.
//  Sits between pixel binariser and frame writer in the image-processing path.
// PARAMETERS
//  IMG_W  256  pixels per row (>=3)
//  IMG_H  256  rows per frame (>=2)
// PORTS
//  clock      in   1        rising-edge clock
//  reset      in   1        asynchronous, active-high
//  mode       in   2        00 erode, 01 dilate, 10 edge (dilate & ~erode), 11 bypass (centre tap)
//  in_valid   in   1        input pixel valid
//  in_ready   out  1        block accepts pixel; accept = in_valid & in_ready
//  in_sof     in   1        marks the first pixel of a frame (qualified by accept)
//  in_pixel   in   1        binary pixel
//  out_valid  out  1        output pixel valid, one-cycle pulse per pixel, no backpressure
//  out_pixel  out  1        filtered pixel
//  out_sof    out  1        with out_valid on output (0,0)
//  out_eof    out  1        with out_valid on output (IMG_H-1, IMG_W-1)
//  err_abort  out  1        1-cycle pulse: frame aborted by an early in_sof
// BEHAVIOUR
//  - Reset: state IDLE, all counters 0, line buffer 0, mode register 00;
//    in_ready=1, out_valid=out_pixel=out_sof=out_eof=err_abort=0.
//  - FSM: IDLE -> FILL -> RUN -> FLUSH -> IDLE.
//    IDLE: accepts only in_sof pixels (others consumed and dropped); on sof, latch mode, go FILL.
//    FILL: first IMG_W+1 pixels accepted, no output; last FILL accept -> RUN.
//    RUN: each accept emits exactly one output; accept of pixel (IMG_H-1, IMG_W-1) -> FLUSH.
//    FLUSH: in_ready=0; shift one dummy 0 per cycle for IMG_W+1 cycles, one output per cycle; then IDLE.
//  - Window advances only on accept (RUN/FILL) or every cycle (FLUSH); in_valid gaps stall without loss.
//  - Latency: output (r,c) is registered in the cycle after accepting pixel (r+1,c+1),
//    i.e. IMG_W+1 pixels + 1 clock; last IMG_W+1 outputs come from FLUSH.
//  - Line buffer: 2*IMG_W+3 bit shift register; taps form 3x3 window centred on output (orow,ocol).
//  - Border mask from output counters: tap valid iff orow+dr in [0,IMG_H-1] and ocol+dc in [0,IMG_W-1].
//    Erode = AND of valid taps; dilate = OR of valid taps; no horizontal wrap between rows.
//  - Counters: input col/row and output col/row, wrap at IMG_W-1 and IMG_H-1; widths $clog2(IMG_W) and $clog2(IMG_H).
//  - mode sampled only on sof accept; changes mid-frame ignored until the next frame.
//  - in_sof accepted in FILL/RUN: err_abort pulses next cycle; pending outputs of the old frame
//    are dropped (no out_eof); buffer cleared; this pixel is (0,0) of a new frame; mode re-latched.
//  - in_sof on a non-first pixel of RUN while it is also the last pixel: treated as abort.
//  - Async reset mid-frame/mid-FLUSH: outputs return to reset values immediately, no partial frame resumes.
// STRUCTURE
//  - Package morph_pkg: typedef enum {MODE_ERODE, MODE_DILATE, MODE_EDGE, MODE_BYPASS} morph_mode_t;
//    typedef enum {S_IDLE, S_FILL, S_RUN, S_FLUSH} morph_state_t.
//  - Sub-module morph_window3x3 #(IMG_W): shift-register line buffer, shift enable, clear,
//    outputs the 9 taps.
//    Top holds FSM, counters, border mask, mode mux, output registers.
// TESTING (IMG_W=8, IMG_H=4)
//  1. All-ones frame, erode -> 32 outputs all 1 (borders not eroded), out_sof on #1, out_eof on #32.
//  2. Single 1 at (2,3), dilate -> 1s exactly at rows 1-3, cols 2-4 (9 px); edge mode -> same 9 px.
//  3. Single 1 at (1,7), dilate -> 1s at rows 0-2, cols 6-7 only; col 0 of rows 1-3 stays 0 (no wrap).
//  4. Continuous valid: first out_valid one cycle after accepting the 10th pixel; after the 32nd pixel
//     in_ready=0 for 9 cycles; in_valid toggled 1/0 gives identical output data.
//  5. in_sof again at pixel 12 -> err_abort pulse, no out_eof for frame 1, new frame completes with 32 outputs.
//  6. Mode switched 00->01 mid-frame -> whole frame eroded; async reset during FLUSH -> outputs 0, in_ready=1.

Source files
------------

// File: rtl/morph_pkg.sv
// Shared types and helpers for the streaming 3x3 binary morphology block.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package morph_pkg;

  // Operation selected per frame; encodings match the external mode pins.
  typedef enum logic [1:0] {
    MODE_ERODE  = 2'b00,
    MODE_DILATE = 2'b01,
    MODE_EDGE   = 2'b10,
    MODE_BYPASS = 2'b11
  } morph_mode_t;

  // Frame sequencing states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FILL  = 2'b01,
    S_RUN   = 2'b10,
    S_FLUSH = 2'b11
  } morph_state_t;

  // Taps are numbered (dr+1)*3 + (dc+1); the centre tap is 4.
  localparam int NTAPS      = 9;
  localparam int TAP_CENTRE = 4;

  // Position in the window view (0 = pixel entering this cycle) of the
  // tap at row offset dr, column offset dc from the output pixel.
  function automatic int tap_idx(input int w, input int dr, input int dc);
    return w + 1 - dr * w - dc;
  endfunction

endpackage

// File: rtl/morph_window3x3.sv
// Line buffer producing the 3x3 neighbourhood of the pixel IMG_W+1 positions behind the input.
// Latency: taps are combinational on the stored bits plus the incoming bit (din is tap view 0).
// Backpressure: none; the window only moves when shift is asserted, clear zeroes the history.
module morph_window3x3
  import morph_pkg::*;
#(
  parameter int IMG_W = 256
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shift,
  input  logic             clear,
  input  logic             din,
  output logic [NTAPS-1:0] taps
);

  // The 2*IMG_W+3 pixel window is the incoming bit plus 2*IMG_W+2 stored bits,
  // so an output can be registered in the same edge that accepts its last tap.
  localparam int SRW = 2 * IMG_W + 2;

  logic [SRW-1:0] sr;
  logic [SRW:0]   view;

  assign view = {sr, din};

  // Pick the nine neighbourhood taps out of the window view.
  for (genvar i = 0; i < 3; i++) begin : g_row
    for (genvar j = 0; j < 3; j++) begin : g_col
      localparam int K = tap_idx(IMG_W, i - 1, j - 1);
      assign taps[i*3+j] = view[K];
    end
  end

  // History shift register; a clear with shift starts a fresh frame with din as its first pixel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else if (clear) begin
      sr <= shift ? {{(SRW-1){1'b0}}, din} : '0;
    end else if (shift) begin
      sr <= {sr[SRW-2:0], din};
    end
  end

endmodule

// File: rtl/morph_filter_stream.sv
// Streaming 3x3 erode/dilate/edge/bypass on 1-bit raster frames with border-aware taps.
// Latency: output (r,c) registered one clock after accepting pixel (r+1,c+1); last IMG_W+1 outputs from flush.
// Backpressure: in_ready drops only while flushing the tail of a frame; outputs cannot be stalled.
module morph_filter_stream
  import morph_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_sof,
  input  logic       in_pixel,
  output logic       out_valid,
  output logic       out_pixel,
  output logic       out_sof,
  output logic       out_eof,
  output logic       err_abort
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  morph_state_t state;
  morph_mode_t  mode_q;

  logic [CW-1:0] icol, ocol;
  logic [RW-1:0] irow, orow;

  logic             accept, start, abort, flushing, emit;
  logic             win_shift, win_clear, win_din;
  logic [NTAPS-1:0] taps;
  logic [2:0]       row_ok, col_ok;
  logic [NTAPS-1:0] ero_in, dil_in;
  logic             eroded, dilated, result;
  logic             in_last;

  // Handshake and window control decoded from the current state.
  always_comb begin
    accept    = in_valid & in_ready;
    flushing  = (state == S_FLUSH);
    start     = accept & in_sof & (state == S_IDLE);
    abort     = accept & in_sof & ((state == S_FILL) | (state == S_RUN));
    // Non-sof pixels seen while idle are consumed but never enter the window.
    win_shift = (accept & (state != S_IDLE)) | start | flushing;
    win_clear = start | abort;
    win_din   = flushing ? 1'b0 : in_pixel;
    emit      = ((state == S_RUN) & accept & ~in_sof) | flushing;
    in_last   = (irow == ROW_LAST) & (icol == COL_LAST);
  end

  morph_window3x3 #(
    .IMG_W(IMG_W)
  ) u_window (
    .clock(clock),
    .reset(reset),
    .shift(win_shift),
    .clear(win_clear),
    .din  (win_din),
    .taps (taps)
  );

  // Taps falling outside the frame are excluded, which also stops row wrap.
  always_comb begin
    row_ok = {orow != ROW_LAST, 1'b1, orow != '0};
    col_ok = {ocol != COL_LAST, 1'b1, ocol != '0};
  end

  for (genvar i = 0; i < 3; i++) begin : g_mrow
    for (genvar j = 0; j < 3; j++) begin : g_mcol
      assign ero_in[i*3+j] = ~(row_ok[i] & col_ok[j]) | taps[i*3+j];
      assign dil_in[i*3+j] = row_ok[i] & col_ok[j] & taps[i*3+j];
    end
  end

  // Apply the frame's latched operation to the masked neighbourhood.
  always_comb begin
    eroded  = &ero_in;
    dilated = |dil_in;
    case (mode_q)
      MODE_ERODE:  result = eroded;
      MODE_DILATE: result = dilated;
      MODE_EDGE:   result = dilated & ~eroded;
      MODE_BYPASS: result = taps[TAP_CENTRE];
      default:     result = 1'b0;
    endcase
  end

  // Frame FSM, position counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      mode_q    <= MODE_ERODE;
      icol      <= '0;
      irow      <= '0;
      ocol      <= '0;
      orow      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_pixel <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      err_abort <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_pixel <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      err_abort <= 1'b0;

      if (emit) begin
        out_valid <= 1'b1;
        out_pixel <= result;
        out_sof   <= (orow == '0) & (ocol == '0);
        out_eof   <= (orow == ROW_LAST) & (ocol == COL_LAST);
        if (ocol == COL_LAST) begin
          ocol <= '0;
          orow <= (orow == ROW_LAST) ? '0 : orow + 1'b1;
        end else begin
          ocol <= ocol + 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= morph_mode_t'(mode);
            icol   <= CW'(1);
            irow   <= '0;
            ocol   <= '0;
            orow   <= '0;
            state  <= S_FILL;
          end
        end
        S_FILL, S_RUN: begin
          if (abort) begin
            // The early sof pixel becomes (0,0) of a new frame; old outputs are dropped.
            err_abort <= 1'b1;
            mode_q    <= morph_mode_t'(mode);
            icol      <= CW'(1);
            irow      <= '0;
            ocol      <= '0;
            orow      <= '0;
            state     <= S_FILL;
          end else if (accept) begin
            if (icol == COL_LAST) begin
              icol <= '0;
              irow <= (irow == ROW_LAST) ? '0 : irow + 1'b1;
            end else begin
              icol <= icol + 1'b1;
            end
            if (state == S_FILL && irow == RW'(1) && icol == '0) begin
              state <= S_RUN;
            end else if (state == S_RUN && in_last) begin
              state    <= S_FLUSH;
              in_ready <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          if (orow == ROW_LAST && ocol == COL_LAST) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morph_filter_stream.sv
// Self-checking bench for morph_filter_stream with an 8x4 frame and a neighbourhood reference model.
// Latency: n/a.
// Backpressure: driver waits on in_ready for every pixel, bounded.
module tb_morph_filter_stream;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int NPIX = W * H;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic       in_pixel = 1'b0;
  logic       in_ready, out_valid, out_pixel, out_sof, out_eof, err_abort;

  morph_filter_stream #(.IMG_W(W), .IMG_H(H)) dut (
    .clock    (clock),
    .reset    (reset),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sof   (in_sof),
    .in_pixel (in_pixel),
    .out_valid(out_valid),
    .out_pixel(out_pixel),
    .out_sof  (out_sof),
    .out_eof  (out_eof),
    .err_abort(err_abort)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int abort_cnt = 0;
  int rdy_low_cnt = 0;
  int first_out_cyc = -1;
  int acc_cyc[NPIX];
  bit pix_q[$];
  bit sof_q[$];
  bit eof_q[$];
  bit saved_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: apply the 3x3 rule directly on the whole frame.
  function automatic bit model_px(input logic [NPIX-1:0] im, input logic [1:0] m,
                                  input int r, input int c);
    bit e = 1'b1;
    bit d = 1'b0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int rr = r + dr;
        int cc = c + dc;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
          e = e & im[rr*W+cc];
          d = d | im[rr*W+cc];
        end
      end
    end
    case (m)
      2'b00:   return e;
      2'b01:   return d;
      2'b10:   return d & ~e;
      default: return im[r*W+c];
    endcase
  endfunction

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Output monitor, sampling on the falling edge.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      if (out_valid) begin
        if (pix_q.size() == 0) first_out_cyc = cyc;
        pix_q.push_back(out_pixel);
        sof_q.push_back(out_sof);
        eof_q.push_back(out_eof);
      end
      if (err_abort) abort_cnt++;
      if (!in_ready) rdy_low_cnt++;
    end
  end

  task automatic clear_mon();
    pix_q.delete();
    sof_q.delete();
    eof_q.delete();
    abort_cnt = 0;
    rdy_low_cnt = 0;
    first_out_cyc = -1;
  endtask

  task automatic send_px(input bit sof, input bit pix, output int acc_at);
    in_valid = 1'b1;
    in_sof   = sof;
    in_pixel = pix;
    acc_at   = -1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clock);
      if (in_ready) begin
        acc_at = cyc;
        @(posedge clock);
        #1;
        break;
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pixel = 1'b0;
    if (acc_at < 0) check_eq("accept_wait", 32'(in_ready), 1);
  endtask

  task automatic send_frame(input logic [NPIX-1:0] im, input logic [1:0] m, input int gap_pct,
                            input int flip_at, input logic [1:0] flip_mode, input int npx);
    mode = m;
    for (int i = 0; i < npx; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        int n = (gap_pct >= 100) ? 1 : int'($urandom_range(3, 1));
        repeat (n) begin
          @(posedge clock);
          #1;
        end
      end
      if (i == flip_at) mode = flip_mode;
      send_px(i == 0, im[i], acc_cyc[i]);
    end
  endtask

  task automatic wait_out(input int n);
    for (int t = 0; t < 400; t++) begin
      if (pix_q.size() >= n) break;
      @(posedge clock);
      #1;
    end
    repeat (12) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_frame(input string tag, input logic [NPIX-1:0] im, input logic [1:0] m,
                             input int base);
    for (int i = 0; i < NPIX; i++) begin
      if (base + i < pix_q.size()) begin
        check_eq($sformatf("%s_pix[%0d]", tag, i), 32'(pix_q[base+i]),
                 32'(model_px(im, m, i / W, i % W)));
        check_eq($sformatf("%s_sof[%0d]", tag, i), 32'(sof_q[base+i]), 32'(i == 0));
        check_eq($sformatf("%s_eof[%0d]", tag, i), 32'(eof_q[base+i]), 32'(i == NPIX - 1));
      end
    end
  endtask

  task automatic run_frame(input string tag, input logic [NPIX-1:0] im, input logic [1:0] m,
                           input int gap_pct, input int flip_at, input logic [1:0] flip_mode,
                           input logic [1:0] exp_m);
    clear_mon();
    send_frame(im, m, gap_pct, flip_at, flip_mode, NPIX);
    wait_out(NPIX);
    check_eq({tag, "_count"}, pix_q.size(), NPIX);
    check_frame(tag, im, exp_m, 0);
  endtask

  initial begin
    logic [NPIX-1:0] im, im_b;
    logic [1:0]      m;
    int              n_before;

    // Reset values, during and just after reset.
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 1);
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_pixel", 32'(out_pixel), 0);
    check_eq("rst_out_sof", 32'(out_sof), 0);
    check_eq("rst_out_eof", 32'(out_eof), 0);
    check_eq("rst_err_abort", 32'(err_abort), 0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_eq("post_rst_in_ready", 32'(in_ready), 1);
    check_eq("post_rst_out_valid", 32'(out_valid), 0);

    // All ones eroded: borders must not erode.
    run_frame("ones_erode", '1, 2'b00, 0, -1, 2'b00, 2'b00);

    // Single dot at (2,3): dilate and edge give the same 3x3 block.
    im = '0;
    im[2*W+3] = 1'b1;
    run_frame("dot_dilate", im, 2'b01, 0, -1, 2'b00, 2'b01);
    run_frame("dot_edge", im, 2'b10, 0, -1, 2'b00, 2'b10);

    // Dot on the right edge at (1,7): nothing may wrap into column 0.
    im = '0;
    im[1*W+7] = 1'b1;
    run_frame("dot_nowrap", im, 2'b01, 0, -1, 2'b00, 2'b01);
    check_eq("nowrap_r1c0", 32'(pix_q[1*W]), 0);
    check_eq("nowrap_r2c0", 32'(pix_q[2*W]), 0);
    check_eq("nowrap_r0c6", 32'(pix_q[6]), 1);

    // Continuous stream: latency and flush length; then the same frame with valid toggling.
    im = $urandom();
    m  = 2'($urandom_range(3));
    run_frame("cont", im, m, 0, -1, 2'b00, m);
    check_eq("first_out_latency", 32'(first_out_cyc - acc_cyc[W+1]), 1);
    check_eq("flush_rdy_low", 32'(rdy_low_cnt), W + 1);
    saved_q = pix_q;
    run_frame("toggle", im, m, 100, -1, 2'b00, m);
    for (int i = 0; i < NPIX; i++) begin
      if (i < pix_q.size() && i < saved_q.size())
        check_eq($sformatf("toggle_same[%0d]", i), 32'(pix_q[i]), 32'(saved_q[i]));
    end

    // Randomised frames with random gaps and modes.
    for (int f = 0; f < 5; f++) begin
      im = $urandom();
      m  = 2'($urandom_range(3));
      run_frame($sformatf("rand%0d", f), im, m, int'($urandom_range(60)), -1, 2'b00, m);
    end

    // Early sof on the 13th pixel aborts frame A; frame B completes normally.
    clear_mon();
    im   = $urandom();
    im_b = $urandom();
    send_frame(im, 2'b01, 0, -1, 2'b00, 12);
    send_frame(im_b, 2'b00, 0, -1, 2'b00, NPIX);
    wait_out(NPIX + 3);
    check_eq("abort_pulses", 32'(abort_cnt), 1);
    check_eq("abort_count", pix_q.size(), NPIX + 3);
    for (int i = 0; i < 3; i++) begin
      if (i < pix_q.size()) begin
        check_eq($sformatf("abortA_pix[%0d]", i), 32'(pix_q[i]), 32'(model_px(im, 2'b01, 0, i)));
        check_eq($sformatf("abortA_eof[%0d]", i), 32'(eof_q[i]), 0);
      end
    end
    check_frame("abortB", im_b, 2'b00, 3);

    // Mode changed mid-frame is ignored: whole frame stays eroded.
    im = $urandom();
    run_frame("mode_flip", im, 2'b00, 0, 10, 2'b01, 2'b00);

    // Asynchronous reset in the middle of flush.
    clear_mon();
    send_frame($urandom(), 2'b01, 0, -1, 2'b00, NPIX);
    repeat (3) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check_eq("flushrst_out_valid", 32'(out_valid), 0);
    check_eq("flushrst_out_pixel", 32'(out_pixel), 0);
    check_eq("flushrst_out_eof", 32'(out_eof), 0);
    check_eq("flushrst_in_ready", 32'(in_ready), 1);
    n_before = pix_q.size();
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (20) begin
      @(posedge clock);
      #1;
    end
    check_eq("flushrst_no_resume", pix_q.size(), n_before);

    // Clean frame after the reset.
    im = $urandom();
    run_frame("after_rst", im, 2'b10, 20, -1, 2'b00, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
